// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: instruction-fetch PC register with prioritised redirects.
// Selects the highest-index redirect request and holds one pending request
// while fetch is stalled. A misaligned redirect target vectors to TRAP_VECTOR.
module pc_redirect_unit #(
    parameter int unsigned            XLEN         = 32,
    parameter int unsigned            NUM_SRC      = 4,
    parameter logic [XLEN-1:0]        RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]        TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned            SRC_W        = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [NUM_SRC-1:0]        redir_valid,
    input  logic [NUM_SRC*XLEN-1:0]   redir_target,
    output logic [XLEN-1:0]           pc_if,
    output logic [XLEN-1:0]           pc_next,
    output logic                      pc_valid,
    output logic                      flush,
    output logic [SRC_W-1:0]          redir_src,
    output logic                      misalign
);

    logic                 pend_valid;
    logic [SRC_W-1:0]     pend_src;
    logic [XLEN-1:0]      pend_target;

    logic                 new_valid;
    logic [SRC_W-1:0]     new_src;
    logic [XLEN-1:0]      new_target;

    logic                 new_wins;
    logic                 cand_valid;
    logic [SRC_W-1:0]     cand_src;
    logic [XLEN-1:0]      cand_target;
    logic                 cand_misalign;
    logic                 apply;

    // Fixed-priority pick of the incoming requests; ascending scan lets the highest index win.
    always_comb begin
        new_valid  = 1'b0;
        new_src    = '0;
        new_target = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (redir_valid[i]) begin
                new_valid  = 1'b1;
                new_src    = SRC_W'(i);
                new_target = redir_target[i*XLEN +: XLEN];
            end
        end
    end

    // Arbitrate new request against pending one and form the next PC.
    always_comb begin
        new_wins      = new_valid && (!pend_valid || (new_src >= pend_src));
        cand_valid    = new_wins || pend_valid;
        cand_src      = new_wins ? new_src    : pend_src;
        cand_target   = new_wins ? new_target : pend_target;
        cand_misalign = (cand_target[1:0] != 2'b00);
        apply         = !rst && !stall && cand_valid;

        if (rst) begin
            pc_next = RESET_VECTOR;
        end else if (stall) begin
            pc_next = pc_if;
        end else if (cand_valid) begin
            pc_next = cand_misalign ? TRAP_VECTOR : cand_target;
        end else begin
            pc_next = pc_if + XLEN'(4);
        end
    end

    // PC, status outputs and pending-redirect register.
    always_ff @(posedge clk) begin
        pc_if <= pc_next;
        if (rst) begin
            pc_valid    <= 1'b0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
            redir_src   <= '0;
            pend_valid  <= 1'b0;
            pend_src    <= '0;
            pend_target <= '0;
        end else begin
            pc_valid <= 1'b1;
            flush    <= apply;
            misalign <= apply && cand_misalign;
            if (apply) begin
                redir_src <= cand_src;
            end
            // Under stall the winner either replaces the pending entry or is dropped;
            // without stall the pending entry is always consumed or superseded.
            if (stall) begin
                if (new_wins) begin
                    pend_valid  <= 1'b1;
                    pend_src    <= new_src;
                    pend_target <= new_target;
                end
            end else begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: behavioural model compared every
// cycle plus directed scenarios with literal expectations.
module tb_pc_redirect_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SRC_W   = 2;
    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam logic [31:0] TV      = 32'h0000_0100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stall;
    logic [NUM_SRC-1:0]      redir_valid;
    logic [NUM_SRC*XLEN-1:0] redir_target;
    logic [XLEN-1:0]         pc_if;
    logic [XLEN-1:0]         pc_next;
    logic                    pc_valid;
    logic                    flush;
    logic [SRC_W-1:0]        redir_src;
    logic                    misalign;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .SRC_W(SRC_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .pc_if(pc_if), .pc_next(pc_next),
        .pc_valid(pc_valid), .flush(flush), .redir_src(redir_src), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_valid, m_flush, m_mis;
    int          m_src;
    bit          pend_v;
    int          pend_s;
    logic [31:0] pend_t;

    function automatic logic [31:0] tgt(input int i);
        logic [NUM_SRC*XLEN-1:0] v;
        v = redir_target;
        return v[i*32 +: 32];
    endfunction

    function automatic int winner();
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (redir_valid[i]) return i;
        return -1;
    endfunction

    // Chosen redirect this cycle if unstalled: -2 none, -1 pending, else new index.
    function automatic int choice();
        int w;
        w = winner();
        if (w >= 0 && (!pend_v || w >= pend_s)) return w;
        if (pend_v) return -1;
        return -2;
    endfunction

    function automatic logic [31:0] model_next();
        int c;
        logic [31:0] t;
        if (rst) return RV;
        if (stall) return m_pc;
        c = choice();
        if (c == -2) return m_pc + 32'd4;
        t = (c == -1) ? pend_t : tgt(c);
        return (t % 4 != 0) ? TV : t;
    endfunction

    always @(posedge clk) begin
        int c, w;
        logic [31:0] t, nxt;
        nxt = model_next();
        if (rst) begin
            m_init = 1'b1;
            m_pc = RV; m_valid = 0; m_flush = 0; m_mis = 0; m_src = 0; pend_v = 0;
        end else if (stall) begin
            w = winner();
            if (w >= 0 && (!pend_v || w >= pend_s)) begin
                pend_v = 1; pend_s = w; pend_t = tgt(w);
            end
            m_pc = nxt; m_valid = 1; m_flush = 0; m_mis = 0;
        end else begin
            c = choice();
            m_flush = 0; m_mis = 0;
            if (c != -2) begin
                t = (c == -1) ? pend_t : tgt(c);
                m_src   = (c == -1) ? pend_s : c;
                m_flush = 1;
                m_mis   = (t % 4 != 0);
            end
            pend_v = 0;
            m_pc = nxt; m_valid = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("model pc_if",     pc_if,              m_pc);
            check("model pc_next",   pc_next,            model_next());
            check("model pc_valid",  32'(pc_valid),      32'(m_valid));
            check("model flush",     32'(flush),         32'(m_flush));
            check("model misalign",  32'(misalign),      32'(m_mis));
            check("model redir_src", 32'(redir_src),     32'(m_src));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [31:0] t);
        redir_valid[i] = 1'b1;
        redir_target[i*32 +: 32] = t;
    endtask

    task automatic clr();
        redir_valid = '0;
    endtask

    initial begin
        rst = 1; stall = 0; redir_valid = '0; redir_target = '0;
        step(); step();
        check("reset pc_if", pc_if, 32'h0);
        check("reset pc_valid", 32'(pc_valid), 0);
        check("reset flush", 32'(flush), 0);
        check("reset pc_next", pc_next, RV);

        // Reset release free-run
        rst = 0;
        step(); check("seq pc 4", pc_if, 32'h4); check("seq valid", 32'(pc_valid), 1);
        step(); check("seq pc 8", pc_if, 32'h8);
        step(); check("seq pc C", pc_if, 32'hC);
        step(); check("seq pc 10", pc_if, 32'h10);

        // Simultaneous redirects: highest index wins
        req(0, 32'h200); req(2, 32'h300); #1;
        check("simul pc_next", pc_next, 32'h300);
        step(); clr();
        check("simul pc", pc_if, 32'h300); check("simul flush", 32'(flush), 1);
        check("simul src", 32'(redir_src), 2);
        step(); check("simul pc+4", pc_if, 32'h304); check("simul flush off", 32'(flush), 0);

        // Move to 0x40, then pending under stall
        req(0, 32'h40); step(); clr();
        stall = 1; req(1, 32'h80); step(); clr();
        check("stall hold", pc_if, 32'h40); check("stall no flush", 32'(flush), 0);
        req(0, 32'h90); step(); clr();
        step();
        check("stall hold 3", pc_if, 32'h40);
        stall = 0; step();
        check("pend pc", pc_if, 32'h80); check("pend src", 32'(redir_src), 1);

        // Pending src2 loses to new src3 on release
        stall = 1; req(2, 32'h500); step(); clr(); step();
        stall = 0; req(3, 32'h600); step(); clr();
        check("pvn pc", pc_if, 32'h600); check("pvn src", 32'(redir_src), 3);
        step(); check("pvn lost", pc_if, 32'h604);

        // Equal index on release: new request wins over pending
        stall = 1; req(2, 32'h700); step(); clr();
        stall = 0; req(2, 32'h800); step(); clr();
        check("eq pc", pc_if, 32'h800);

        // Higher index replaces pending under stall
        stall = 1; req(1, 32'h900); step(); clr(); req(3, 32'hA00); step(); clr();
        stall = 0; step();
        check("replace pc", pc_if, 32'hA00); check("replace src", 32'(redir_src), 3);

        // Misaligned target
        req(1, 32'h102); step(); clr();
        check("mis pc", pc_if, TV); check("mis flag", 32'(misalign), 1);
        check("mis flush", 32'(flush), 1); check("mis src", 32'(redir_src), 1);
        step(); check("mis off", 32'(misalign), 0); check("mis pc+4", pc_if, 32'h104);

        // Wrap-around
        req(0, 32'hFFFF_FFFC); step(); clr();
        step(); check("wrap pc", pc_if, 32'h0);

        // Reset mid-operation with pending request under stall
        stall = 1; req(3, 32'hB00); step(); clr();
        rst = 1; #1; check("rst pc_next", pc_next, RV);
        step();
        rst = 0; stall = 0;
        check("rst2 pc", pc_if, 32'h0); check("rst2 valid", 32'(pc_valid), 0);
        step(); check("rst2 pc 4", pc_if, 32'h4); check("rst2 no flush", 32'(flush), 0);
        step(); check("rst2 pc 8", pc_if, 32'h8); check("rst2 no flush b", 32'(flush), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
